// File: rtl/io_channel_fifo.sv
// Buffered multi-channel I/O port: per channel, one CPU->pin output FIFO and one pin->CPU input
// FIFO, with valid/ready handshakes on the pin side and go/gi strobes on the CPU side.
module io_channel_fifo #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CHW      = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHW-1:0]            chan,
    input  logic                      go,
    input  logic                      gi,
    input  logic [WIDTH-1:0]          wdata,
    output logic [WIDTH-1:0]          rdata,
    output logic                      stall,
    output logic                      err,
    output logic [CHANNELS-1:0]       o_full,
    output logic [CHANNELS-1:0]       i_empty,
    output logic [CHANNELS*WIDTH-1:0] oport_data,
    output logic [CHANNELS-1:0]       oport_valid,
    input  logic [CHANNELS-1:0]       oport_ready,
    input  logic [CHANNELS*WIDTH-1:0] iport_data,
    input  logic [CHANNELS-1:0]       iport_valid,
    output logic [CHANNELS-1:0]       iport_ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    logic [CHANNELS-1:0]            w_hit;
    logic [CHANNELS-1:0]            w_osel;
    logic [CHANNELS-1:0]            w_isel;
    logic [CHANNELS-1:0][WIDTH-1:0] w_ihead;
    logic                           r_err;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [WIDTH-1:0] r_omem [DEPTH];
        logic [WIDTH-1:0] r_imem [DEPTH];
        logic [PW-1:0]    r_ord;
        logic [PW-1:0]    r_owr;
        logic [PW-1:0]    r_ird;
        logic [PW-1:0]    r_iwr;
        logic [CW-1:0]    r_ocnt;
        logic [CW-1:0]    r_icnt;
        logic             w_opush;
        logic             w_opop;
        logic             w_ipush;
        logic             w_ipop;

        // Out-of-range chan values match no channel, so they are silently ignored.
        assign w_hit[k]  = (chan == CHW'(k));
        assign w_osel[k] = go & w_hit[k];
        assign w_isel[k] = gi & w_hit[k];

        assign o_full[k]      = (r_ocnt == FullCnt);
        assign oport_valid[k] = (r_ocnt != '0);
        assign i_empty[k]     = (r_icnt == '0);
        assign iport_ready[k] = (r_icnt != FullCnt) && reset_n;

        // Eligibility uses pre-edge counts only: no bypass through a full or empty FIFO.
        assign w_opush = w_osel[k] && !o_full[k];
        assign w_opop  = oport_valid[k] && oport_ready[k];
        assign w_ipush = iport_valid[k] && iport_ready[k];
        assign w_ipop  = w_isel[k] && !i_empty[k];

        assign oport_data[k*WIDTH +: WIDTH] = r_omem[r_ord];
        assign w_ihead[k]                   = r_imem[r_ird];

        always_ff @(posedge clk) begin
            if (w_opush) r_omem[r_owr] <= wdata;
            if (w_ipush) r_imem[r_iwr] <= iport_data[k*WIDTH +: WIDTH];
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_ord  <= '0;
                r_owr  <= '0;
                r_ird  <= '0;
                r_iwr  <= '0;
                r_ocnt <= '0;
                r_icnt <= '0;
            end else begin
                if (w_opush) r_owr <= r_owr + PW'(1);
                if (w_opop)  r_ord <= r_ord + PW'(1);
                if (w_ipush) r_iwr <= r_iwr + PW'(1);
                if (w_ipop)  r_ird <= r_ird + PW'(1);
                if (w_opush && !w_opop)      r_ocnt <= r_ocnt + CW'(1);
                else if (!w_opush && w_opop) r_ocnt <= r_ocnt - CW'(1);
                if (w_ipush && !w_ipop)      r_icnt <= r_icnt + CW'(1);
                else if (!w_ipush && w_ipop) r_icnt <= r_icnt - CW'(1);
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_hit[k] && !i_empty[k]) rdata = w_ihead[k];
        end
    end

    assign stall = (|(w_osel & o_full)) | (|(w_isel & i_empty));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_err <= 1'b0;
        else          r_err <= r_err | stall;
    end

    assign err = r_err;

endmodule

// File: tb/tb_io_channel_fifo.sv
// Directed self-checking bench for io_channel_fifo with 2 channels of 4-deep, 8-bit FIFOs.
module tb_io_channel_fifo;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [0:0]  chan;
    logic        go;
    logic        gi;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        stall;
    logic        err;
    logic [1:0]  o_full;
    logic [1:0]  i_empty;
    logic [15:0] oport_data;
    logic [1:0]  oport_valid;
    logic [1:0]  oport_ready;
    logic [15:0] iport_data;
    logic [1:0]  iport_valid;
    logic [1:0]  iport_ready;

    int checks   = 0;
    int failures = 0;

    io_channel_fifo #(
        .WIDTH    (8),
        .DEPTH    (4),
        .CHANNELS (2),
        .CHW      (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .chan        (chan),
        .go          (go),
        .gi          (gi),
        .wdata       (wdata),
        .rdata       (rdata),
        .stall       (stall),
        .err         (err),
        .o_full      (o_full),
        .i_empty     (i_empty),
        .oport_data  (oport_data),
        .oport_valid (oport_valid),
        .oport_ready (oport_ready),
        .iport_data  (iport_data),
        .iport_valid (iport_valid),
        .iport_ready (iport_ready)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        chan        = 1'b0;
        go          = 1'b0;
        gi          = 1'b0;
        wdata       = 8'h00;
        oport_ready = 2'b00;
        iport_data  = 16'h0000;
        iport_valid = 2'b00;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if (oport_valid !== 2'b00) begin
            failures++;
            $display("FAIL reset_ovalid: got %b want 00", oport_valid);
        end
        checks++;
        if (i_empty !== 2'b11) begin
            failures++;
            $display("FAIL reset_iempty: got %b want 11", i_empty);
        end
        checks++;
        if (iport_ready !== 2'b00) begin
            failures++;
            $display("FAIL reset_iready_low: got %b want 00", iport_ready);
        end
        checks++;
        if (rdata !== 8'h00 || err !== 1'b0 || stall !== 1'b0 || o_full !== 2'b00) begin
            failures++;
            $display("FAIL reset_misc: got rdata=%h err=%b stall=%b o_full=%b want 00 0 0 00",
                     rdata, err, stall, o_full);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (iport_ready !== 2'b11) begin
            failures++;
            $display("FAIL reset_iready_release: got %b want 11", iport_ready);
        end
    endtask

    task automatic test_output_fill();
        logic [7:0] exp_words [4];
        exp_words = '{8'h11, 8'h22, 8'h33, 8'h44};
        apply_reset();
        chan = 1'b0;
        go   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wdata = exp_words[i];
            tick();
        end
        go = 1'b0;
        checks++;
        if (o_full !== 2'b01 || oport_valid !== 2'b01) begin
            failures++;
            $display("FAIL ofill_full: got o_full=%b ovalid=%b want 01 01", o_full, oport_valid);
        end
        go    = 1'b1;
        wdata = 8'h55;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL ofill_stall: got %b want 1", stall);
        end
        tick();
        go = 1'b0;
        #1;
        checks++;
        if (err !== 1'b1 || stall !== 1'b0) begin
            failures++;
            $display("FAIL ofill_err: got err=%b stall=%b want 1 0", err, stall);
        end
        oport_ready = 2'b01;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (oport_valid[0] !== 1'b1 || oport_data[7:0] !== exp_words[i]) begin
                failures++;
                $display("FAIL ofill_drain%0d: got valid=%b data=%h want 1 %h",
                         i, oport_valid[0], oport_data[7:0], exp_words[i]);
            end
            tick();
        end
        oport_ready = 2'b00;
        checks++;
        if (oport_valid !== 2'b00 || o_full !== 2'b00) begin
            failures++;
            $display("FAIL ofill_empty: got ovalid=%b o_full=%b want 00 00", oport_valid, o_full);
        end
    endtask

    task automatic test_input_ch1();
        apply_reset();
        iport_valid = 2'b10;
        iport_data  = 16'hA000;
        tick();
        iport_data  = 16'hA100;
        tick();
        iport_valid = 2'b00;
        chan        = 1'b1;
        #1;
        checks++;
        if (i_empty !== 2'b01 || rdata !== 8'hA0) begin
            failures++;
            $display("FAIL in1_head: got i_empty=%b rdata=%h want 01 a0", i_empty, rdata);
        end
        gi = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL in1_nostall: got %b want 0", stall);
        end
        tick();
        checks++;
        if (rdata !== 8'hA1) begin
            failures++;
            $display("FAIL in1_second: got %h want a1", rdata);
        end
        tick();
        gi = 1'b0;
        #1;
        checks++;
        if (i_empty !== 2'b11 || rdata !== 8'h00 || err !== 1'b0) begin
            failures++;
            $display("FAIL in1_drained: got i_empty=%b rdata=%h err=%b want 11 00 0",
                     i_empty, rdata, err);
        end
        gi = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1 || rdata !== 8'h00) begin
            failures++;
            $display("FAIL in1_empty_gi: got stall=%b rdata=%h want 1 00", stall, rdata);
        end
        tick();
        gi = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL in1_err: got %b want 1", err);
        end
    endtask

    // Push word t on cycle t and pop word t-2 on the same cycle: two outstanding, pointers wrap.
    task automatic test_wrap();
        apply_reset();
        chan = 1'b0;
        for (int t = 0; t < 12; t++) begin
            iport_valid = (t < 10) ? 2'b01 : 2'b00;
            iport_data  = {8'h00, 8'h30 + 8'(t)};
            gi          = (t >= 2);
            #1;
            if (t >= 2) begin
                checks++;
                if (rdata !== 8'h30 + 8'(t - 2) || stall !== 1'b0) begin
                    failures++;
                    $display("FAIL wrap_word%0d: got rdata=%h stall=%b want %h 0",
                             t - 2, rdata, stall, 8'h30 + 8'(t - 2));
                end
            end
            tick();
        end
        idle_inputs();
        checks++;
        if (i_empty !== 2'b11 || err !== 1'b0) begin
            failures++;
            $display("FAIL wrap_end: got i_empty=%b err=%b want 11 0", i_empty, err);
        end
    endtask

    task automatic test_full_pop_and_push();
        logic [7:0] exp_words [3];
        exp_words = '{8'h22, 8'h33, 8'h44};
        apply_reset();
        chan = 1'b0;
        go   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wdata = 8'h11 * 8'(i + 1);
            tick();
        end
        wdata       = 8'h99;
        oport_ready = 2'b01;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL fullpop_stall: got %b want 1", stall);
        end
        tick();
        go          = 1'b0;
        oport_ready = 2'b00;
        checks++;
        if (err !== 1'b1 || o_full !== 2'b00 || oport_valid !== 2'b01) begin
            failures++;
            $display("FAIL fullpop_state: got err=%b o_full=%b ovalid=%b want 1 00 01",
                     err, o_full, oport_valid);
        end
        oport_ready = 2'b01;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (oport_valid[0] !== 1'b1 || oport_data[7:0] !== exp_words[i]) begin
                failures++;
                $display("FAIL fullpop_drain%0d: got valid=%b data=%h want 1 %h",
                         i, oport_valid[0], oport_data[7:0], exp_words[i]);
            end
            tick();
        end
        oport_ready = 2'b00;
        checks++;
        if (oport_valid !== 2'b00) begin
            failures++;
            $display("FAIL fullpop_count3: got ovalid=%b want 00", oport_valid);
        end
    endtask

    task automatic test_push_pop_same_edge();
        apply_reset();
        chan        = 1'b0;
        iport_valid = 2'b01;
        iport_data  = 16'h00B0;
        tick();
        iport_data = 16'h00B1;
        gi         = 1'b1;
        #1;
        checks++;
        if (rdata !== 8'hB0) begin
            failures++;
            $display("FAIL pushpop_head: got %h want b0", rdata);
        end
        tick();
        iport_valid = 2'b00;
        #1;
        checks++;
        if (rdata !== 8'hB1 || i_empty[0] !== 1'b0) begin
            failures++;
            $display("FAIL pushpop_after: got rdata=%h empty=%b want b1 0", rdata, i_empty[0]);
        end
        tick();
        gi = 1'b0;
        checks++;
        if (i_empty !== 2'b11 || err !== 1'b0) begin
            failures++;
            $display("FAIL pushpop_count1: got i_empty=%b err=%b want 11 0", i_empty, err);
        end
    endtask

    task automatic test_go_gi_same_cycle();
        apply_reset();
        iport_valid = 2'b10;
        iport_data  = 16'hC500;
        tick();
        iport_valid = 2'b00;
        chan        = 1'b1;
        go          = 1'b1;
        gi          = 1'b1;
        wdata       = 8'h5A;
        #1;
        checks++;
        if (rdata !== 8'hC5 || stall !== 1'b0) begin
            failures++;
            $display("FAIL gogi_before: got rdata=%h stall=%b want c5 0", rdata, stall);
        end
        tick();
        go = 1'b0;
        gi = 1'b0;
        #1;
        checks++;
        if (oport_valid !== 2'b10 || oport_data[15:8] !== 8'h5A || i_empty !== 2'b11 ||
            err !== 1'b0) begin
            failures++;
            $display("FAIL gogi_after: got ovalid=%b data=%h i_empty=%b err=%b want 10 5a 11 0",
                     oport_valid, oport_data[15:8], i_empty, err);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            iport_valid = 2'b11;
            iport_data  = {8'hE0 + 8'(i), 8'hD0 + 8'(i)};
            chan        = 1'b0;
            go          = 1'b1;
            wdata       = 8'h70 + 8'(i);
            tick();
        end
        iport_valid = 2'b00;
        chan        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wdata = 8'h80 + 8'(i);
            tick();
        end
        go = 1'b0;
        // A dropped gi strobe on a full channel would not set err; use a fourth + fifth go instead.
        chan = 1'b0;
        go   = 1'b1;
        wdata = 8'h73;
        tick();
        wdata = 8'h74;
        tick();
        go = 1'b0;
        checks++;
        if (oport_valid !== 2'b11 || i_empty !== 2'b00 || err !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_loaded: got ovalid=%b i_empty=%b err=%b want 11 00 1",
                     oport_valid, i_empty, err);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (iport_ready !== 2'b00 || oport_valid !== 2'b00 || err !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async: got iready=%b ovalid=%b err=%b want 00 00 0",
                     iport_ready, oport_valid, err);
        end
        #4;
        reset_n = 1'b1;
        #1;
        checks++;
        if (i_empty !== 2'b11 || o_full !== 2'b00 || iport_ready !== 2'b11) begin
            failures++;
            $display("FAIL rstmid_release: got i_empty=%b o_full=%b iready=%b want 11 00 11",
                     i_empty, o_full, iport_ready);
        end
        tick();
        checks++;
        if (oport_valid !== 2'b00 || err !== 1'b0 || rdata !== 8'h00) begin
            failures++;
            $display("FAIL rstmid_after: got ovalid=%b err=%b rdata=%h want 00 0 00",
                     oport_valid, err, rdata);
        end
    endtask

    initial begin
        test_reset();
        test_output_fill();
        test_input_ch1();
        test_wrap();
        test_full_pop_and_push();
        test_push_pop_same_edge();
        test_go_gi_same_cycle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
